// File: rtl/fifo_read_packer.sv
// Read-side drain for the async FIFO: pulls words in r_clk domain and
// packs PACK of them into one wide word on a valid/ready output.
module fifo_read_packer #(
    parameter int DATA_WIDTH = 4,
    parameter int PACK       = 2,
    parameter int OUT_WIDTH  = DATA_WIDTH * PACK,
    parameter int CNT_WIDTH  = $clog2(PACK + 1)
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_en,
    input  logic                  flush,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [CNT_WIDTH-1:0]  out_nib,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           word_cnt
);

    localparam logic [CNT_WIDTH:0]   PACK_EXT = (CNT_WIDTH + 1)'(PACK);
    localparam logic [CNT_WIDTH-1:0] PACK_CNT = CNT_WIDTH'(PACK);

    logic                 pending;
    logic [CNT_WIDTH-1:0] pack_cnt;
    logic                 flush_req;
    logic [OUT_WIDTH-1:0] asm_reg;

    logic                 out_free;
    logic                 handshake;
    logic                 pack_full;
    logic                 flush_ready;
    logic                 do_xfer;
    logic                 flush_done;
    logic [CNT_WIDTH:0]   committed;

    // Read issue and transfer decisions
    always_comb begin
        committed   = {1'b0, pack_cnt} + {{CNT_WIDTH{1'b0}}, pending};
        r_en        = !empty && !flush_req && (committed < PACK_EXT);
        out_free    = !out_valid || out_ready;
        handshake   = out_valid && out_ready;
        pack_full   = (pack_cnt == PACK_CNT);
        flush_ready = flush_req && !pending;
        do_xfer     = out_free &&
                      (pack_full || (flush_ready && (pack_cnt != '0)));
        flush_done  = flush_ready && ((pack_cnt == '0) || do_xfer);
    end

    // Track the read in flight (data returns one cycle later)
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            pending <= 1'b0;
        end else begin
            pending <= r_en;
        end
    end

    // Assembly register: capture returned words, clear on transfer
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            asm_reg  <= '0;
            pack_cnt <= '0;
        end else if (do_xfer) begin
            asm_reg  <= '0;
            pack_cnt <= '0;
        end else if (pending) begin
            for (int i = 0; i < PACK; i++) begin
                if (pack_cnt == CNT_WIDTH'(i)) begin
                    asm_reg[i*DATA_WIDTH +: DATA_WIDTH] <= r_data;
                end
            end
            pack_cnt <= pack_cnt + 1'b1;
        end
    end

    // Flush request: held until the partial word is out or nothing was held
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            flush_req <= 1'b0;
        end else if (flush_req) begin
            if (flush_done) begin
                flush_req <= 1'b0;
            end
        end else if (flush) begin
            flush_req <= 1'b1;
        end
    end

    // Output register with back-to-back reload on handshake
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            out_data  <= '0;
            out_nib   <= '0;
            out_valid <= 1'b0;
        end else if (do_xfer) begin
            out_data  <= asm_reg;
            out_nib   <= pack_cnt;
            out_valid <= 1'b1;
        end else if (handshake) begin
            out_valid <= 1'b0;
        end
    end

    // Count accepted output words
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            word_cnt <= '0;
        end else if (handshake) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_read_packer.sv
// Bench for fifo_read_packer: FIFO model, packing model and scoreboard,
// plus directed cases with literal expectations.
module tb_fifo_read_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic       empty;
    logic [3:0] r_data;
    logic       r_en;
    logic       flush;
    logic [7:0] out_data;
    logic [1:0] out_nib;
    logic       out_valid;
    logic       out_ready;
    logic [15:0] word_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [3:0] mem [0:1023];
    int wp = 0;
    int rp = 0;

    logic [3:0] part [$];
    logic [7:0] exp_d [$];
    int         exp_n [$];
    logic [7:0] log_d [$];
    int         log_n [$];
    int         log_c [$];
    int         hs_total = 0;
    logic [15:0] base = 16'd0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_d = 8'd0;
    logic [1:0]  prev_n = 2'd0;

    fifo_read_packer #(.DATA_WIDTH(4), .PACK(2)) dut (
        .r_clk(clk),
        .r_rst(rst),
        .empty(empty),
        .r_data(r_data),
        .r_en(r_en),
        .flush(flush),
        .out_data(out_data),
        .out_nib(out_nib),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    assign empty = rst || (rp == wp);

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: registered read data, reset shares r_rst
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rp <= wp;
            r_data <= 4'd0;
        end else if (r_en && rp != wp) begin
            r_data <= mem[rp % 1024];
            rp <= rp + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Packing model: every PACK words pushed form one expected word
    task automatic emit(input int n);
        logic [7:0] w;
        w = 8'd0;
        for (int i = 0; i < n; i++) w[i*4 +: 4] = part[i];
        exp_d.push_back(w);
        exp_n.push_back(n);
        part.delete();
    endtask

    task automatic push(input logic [3:0] v);
        @(negedge clk);
        mem[wp % 1024] = v;
        wp = wp + 1;
        part.push_back(v);
        if (part.size() == 2) emit(2);
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        if (part.size() > 0) emit(part.size());
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (wp == rp && exp_d.size() == 0 && !out_valid) return;
        end
        errors++;
        $display("FAIL %s timeout waiting for idle", name);
    endtask

    // Compare process: scoreboard on handshakes, invariants every cycle
    always @(negedge clk) begin
        if (rst) begin
            hs_total = 0;
            prev_hold = 1'b0;
        end else begin
            if (r_en && empty) chk("r_en_while_empty", 1, 0);
            chk("word_cnt_model", word_cnt, 16'(base + 16'(hs_total)));
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_d);
                chk("hold_nib", out_nib, prev_n);
            end
            if (out_valid && out_ready) begin
                if (exp_d.size() == 0) begin
                    chk("unexpected_word", out_data, 32'hFFFF_FFFF);
                end else begin
                    chk("sb_data", out_data, exp_d.pop_front());
                    chk("sb_nib", out_nib, exp_n.pop_front());
                end
                log_d.push_back(out_data);
                log_n.push_back(out_nib);
                log_c.push_back(cyc);
                hs_total++;
            end
            prev_hold = out_valid && !out_ready;
            prev_d = out_data;
            prev_n = out_nib;
        end
    end

    initial begin
        int k;
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_nib", out_nib, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_r_en", r_en, 0);
        rst = 1'b0;

        push(4'h3); push(4'h5); push(4'hA); push(4'hC);
        wait_idle(100, "t1_idle");
        k = log_d.size();
        chk("t1_w0", log_d[k-2], 8'h53);
        chk("t1_w1", log_d[k-1], 8'hCA);
        chk("t1_nib", log_n[k-1], 2);
        chk("t1_cnt", word_cnt, 2);

        out_ready = 1'b0;
        push(4'h3); push(4'h5); push(4'hA); push(4'hC);
        repeat (12) @(negedge clk);
        chk("t2_valid", out_valid, 1);
        chk("t2_data", out_data, 8'h53);
        chk("t2_r_en", r_en, 0);
        chk("t2_drained", rp, wp);
        out_ready = 1'b1;
        wait_idle(100, "t2_idle");
        k = log_d.size();
        chk("t2_w0", log_d[k-2], 8'h53);
        chk("t2_w1", log_d[k-1], 8'hCA);
        chk("t2_b2b", log_c[k-1] - log_c[k-2], 1);
        chk("t2_cnt", word_cnt, 4);

        push(4'h1); push(4'h2); push(4'h3);
        for (int i = 0; i < 50 && rp != wp; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        do_flush();
        wait_idle(100, "t3_idle");
        k = log_d.size();
        chk("t3_w0", log_d[k-2], 8'h21);
        chk("t3_n0", log_n[k-2], 2);
        chk("t3_w1", log_d[k-1], 8'h03);
        chk("t3_n1", log_n[k-1], 1);
        chk("t3_cnt", word_cnt, 6);

        do_flush();
        for (int i = 0; i < 4; i++) begin
            chk("t4_no_valid", out_valid, 0);
            @(negedge clk);
        end
        push(4'h4); push(4'h6);
        wait_idle(100, "t4_idle");
        chk("t4_w", log_d[log_d.size()-1], 8'h64);
        chk("t4_cnt", word_cnt, 7);

        push(4'h1); push(4'h2);
        for (int i = 0; i < 20 && !r_en; i++) @(negedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        part.delete();
        exp_d.delete();
        exp_n.delete();
        #1;
        chk("t5_valid", out_valid, 0);
        chk("t5_data", out_data, 0);
        chk("t5_nib", out_nib, 0);
        chk("t5_cnt", word_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push(4'h7); push(4'h9);
        wait_idle(100, "t5_idle");
        chk("t5_w", log_d[log_d.size()-1], 8'h97);
        chk("t5_cnt_after", word_cnt, 1);

        @(posedge clk);
        #2;
        force dut.word_cnt = 16'hFFFE;
        #1;
        release dut.word_cnt;
        base = 16'hFFFE - 16'(hs_total);
        push(4'hB); push(4'hD);
        wait_idle(100, "t6_idle_a");
        chk("t6_ffff", word_cnt, 16'hFFFF);
        push(4'hE); push(4'hF);
        wait_idle(100, "t6_idle_b");
        chk("t6_wrap", word_cnt, 16'h0000);
        chk("t6_w", log_d[log_d.size()-1], 8'hFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
